// File: rtl/path_recorder.sv
// Records the rat's move path as a stack, then replays it from the oldest move using a valid/ready handshake.
// Optional PATH_REC_BACKTRACK_EN: Pop removes or overwrites the newest move; when undefined, the raw trace is kept.
module path_recorder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Start,
  input  logic          Push,
  input  logic          Pop,
  input  logic [1:0]    Move_in,
  input  logic          Done,
  input  logic          Fail,
  input  logic          Run,
  input  logic          Out_ready,
  output logic [1:0]    Move_out,
  output logic          Out_valid,
  output logic          Play_done,
  output logic [AW:0]   Count,
  output logic          Overflow
);

  localparam int unsigned CW   = AW + 1;
  localparam logic [AW:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, RECORD, READY, PLAY, FINISH} state_t;

  state_t        state;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    mem [DEPTH];

  logic          pop_en;
  logic          nonempty;
  logic          replace;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

`ifdef PATH_REC_BACKTRACK_EN
  assign pop_en = Pop;
`else
  logic unused_pop;
  assign unused_pop = Pop;
  assign pop_en     = 1'b0;
`endif

  assign nonempty = (Count != '0);
  // Push with Pop at a non-empty stack replaces the newest entry in place.
  assign replace  = Push && pop_en && nonempty;

  // Storage write port; reset and Start suppress any write in the same cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    if (RST && !Start && (state == RECORD) && Push) begin
      if (replace) begin
        wr_en   = 1'b1;
        wr_addr = AW'(Count - CW'(1));
      end else if (Count < FULL) begin
        wr_en   = 1'b1;
        wr_addr = AW'(Count);
      end
    end
  end

  // Storage is deliberately not reset so the path survives replay.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= Move_in;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      Count     <= '0;
      rd_ptr    <= '0;
      Move_out  <= 2'b00;
      Out_valid <= 1'b0;
      Play_done <= 1'b0;
      Overflow  <= 1'b0;
    end else if (Start) begin
      state     <= RECORD;
      Count     <= '0;
      rd_ptr    <= '0;
      Out_valid <= 1'b0;
      Play_done <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        RECORD: begin
          if (Push && !replace) begin
            if (Count < FULL) Count <= Count + CW'(1);
            else              Overflow <= 1'b1;
          end else if (!Push && pop_en && nonempty) begin
            Count <= Count - CW'(1);
          end
          if (Fail) begin
            Count <= '0;
            state <= IDLE;
          end else if (Done) begin
            state <= READY;
          end
        end
        READY, FINISH: begin
          if (Run) begin
            rd_ptr    <= '0;
            Play_done <= 1'b0;
            if (!nonempty) begin
              state <= FINISH;
            end else begin
              state     <= PLAY;
              Out_valid <= 1'b1;
              Move_out  <= mem[AW'(0)];
            end
          end else if (state == FINISH) begin
            Play_done <= 1'b1;
          end
        end
        PLAY: begin
          if (Out_valid && Out_ready) begin
            if ({1'b0, rd_ptr} == Count - CW'(1)) begin
              Out_valid <= 1'b0;
              Play_done <= 1'b1;
              state     <= FINISH;
            end else begin
              rd_ptr   <= rd_ptr + AW'(1);
              Move_out <= mem[rd_ptr + AW'(1)];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_path_recorder.sv
// Randomised bench for path_recorder against a queue-based path model; follows PATH_REC_BACKTRACK_EN.
module tb_path_recorder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
`ifdef PATH_REC_BACKTRACK_EN
  localparam bit BT = 1'b1;
`else
  localparam bit BT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        push;
  logic        pop;
  logic [1:0]  move_in;
  logic        done;
  logic        fail;
  logic        run;
  logic        out_ready;
  logic [1:0]  move_out;
  logic        out_valid;
  logic        play_done;
  logic [AW:0] count;
  logic        overflow;

  path_recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(clk), .RST(rst), .Start(start), .Push(push), .Pop(pop),
    .Move_in(move_in), .Done(done), .Fail(fail), .Run(run),
    .Out_ready(out_ready), .Move_out(move_out), .Out_valid(out_valid),
    .Play_done(play_done), .Count(count), .Overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stored path as a queue, plus the sticky overflow bit.
  logic [1:0] path [$];
  bit         ovf;
  bit         recording;
  int         checks;
  int         errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    path.delete();
    ovf       = 1'b0;
    recording = 1'b1;
    check("start_count", 32'(count), 32'(0));
    check("start_ovf", 32'(overflow), 32'(0));
    check("start_valid", 32'(out_valid), 32'(0));
    check("start_pdone", 32'(play_done), 32'(0));
  endtask

  task automatic cyc(input bit ps, input bit pp, input logic [1:0] mv, input bit dn, input bit fl);
    push = ps; pop = pp; move_in = mv; done = dn; fail = fl;
    step();
    push = 1'b0; pop = 1'b0; done = 1'b0; fail = 1'b0;
    if (recording) begin
      if (ps && BT && pp && path.size() > 0) path[path.size()-1] = mv;
      else if (ps) begin
        if (path.size() < DEPTH) path.push_back(mv);
        else ovf = 1'b1;
      end else if (BT && pp && path.size() > 0) void'(path.pop_back());
      if (fl) begin
        path.delete();
        recording = 1'b0;
      end else if (dn) recording = 1'b0;
    end
    check("count", 32'(count), 32'(path.size()));
    check("overflow", 32'(overflow), 32'(ovf));
  endtask

  // Replays the stored path; out_ready is randomly stalled and may be held low for 5 cycles at hold_at.
  task automatic replay(input int stall_pct, input int hold_at);
    int idx;
    int n;
    int budget;
    int held;
    idx = 0; held = 0;
    n = path.size();
    run = 1'b1;
    step();
    run = 1'b0;
    if (n == 0) begin
      check("empty_valid0", 32'(out_valid), 32'(0));
      check("empty_pdone0", 32'(play_done), 32'(0));
      step();
      check("empty_valid1", 32'(out_valid), 32'(0));
      check("empty_pdone1", 32'(play_done), 32'(1));
      return;
    end
    budget = 4 * n + 40;
    while (idx < n && budget > 0) begin
      check("play_valid", 32'(out_valid), 32'(1));
      check("play_move", 32'(move_out), 32'(path[idx]));
      if (idx == hold_at && held < 5) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
      end
      step();
      if (out_ready) idx++;
      budget--;
    end
    out_ready = 1'b0;
    if (idx < n) check("play_timeout", 32'(idx), 32'(n));
    check("play_end_valid", 32'(out_valid), 32'(0));
    check("play_pdone", 32'(play_done), 32'(1));
    check("play_count", 32'(count), 32'(n));
    step();
    check("finish_pdone", 32'(play_done), 32'(1));
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0; push = 1'b0; pop = 1'b0; move_in = 2'b00;
    done = 1'b0; fail = 1'b0; run = 1'b0; out_ready = 1'b0;
    recording = 1'b0; ovf = 1'b0;
    @(negedge clk);
    step(); step();
    check("rst_count", 32'(count), 32'(0));
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_pdone", 32'(play_done), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    check("rst_move", 32'(move_out), 32'(0));
    rst = 1'b1;
    step();

    // Basic three-move path, then a second replay from FINISH with stalls.
    do_start();
    cyc(1, 0, 2'b01, 0, 0);
    cyc(1, 0, 2'b01, 0, 0);
    cyc(1, 0, 2'b11, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    replay(0, -1);
    replay(40, 1);

    // Backtrack sequence (raw trace when backtracking is disabled).
    do_start();
    cyc(1, 0, 2'b01, 0, 0);
    cyc(1, 0, 2'b11, 0, 0);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(1, 0, 2'b10, 0, 0);
    cyc(1, 1, 2'b00, 0, 0);
    cyc(0, 1, 2'b00, 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    check("bt_count", 32'(count), BT ? 32'(1) : 32'(4));
    replay(25, 0);

    // Random record/backtrack rounds; pushes after Done must be ignored.
    for (int r = 0; r < 6; r++) begin
      int n;
      do_start();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++)
        cyc($urandom_range(99) < 65, $urandom_range(99) < 30, 2'($urandom_range(3)), 0, 0);
      cyc($urandom_range(1), $urandom_range(1), 2'($urandom_range(3)), 1, 0);
      cyc(1, 1, 2'($urandom_range(3)), 0, 0);
      cyc(1, 0, 2'($urandom_range(3)), 0, 0);
      replay(30, $urandom_range(0, 3));
    end

    // Overflow: 257 pushes into a 256-entry store.
    do_start();
    for (int i = 0; i < 257; i++) cyc(1, 0, 2'($urandom_range(3)), 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    check("ovf_count", 32'(count), 32'(256));
    check("ovf_flag", 32'(overflow), 32'(1));
    replay(20, 100);

    // Fail clears the path and Run is then ignored.
    do_start();
    for (int i = 0; i < 5; i++) cyc(1, 0, 2'($urandom_range(3)), 0, 0);
    cyc(1, 0, 2'b10, 0, 1);
    run = 1'b1;
    step();
    run = 1'b0;
    check("fail_valid", 32'(out_valid), 32'(0));
    step();
    check("fail_pdone", 32'(play_done), 32'(0));

    // Empty path: Play_done rises two cycles after Run, Out_valid never set.
    do_start();
    cyc(0, 0, 2'b00, 1, 0);
    replay(0, -1);

    // Reset in mid-replay overrides Start/Push/Run; Run afterwards is ignored.
    do_start();
    for (int i = 0; i < 4; i++) cyc(1, 0, 2'($urandom_range(3)), 0, 0);
    cyc(0, 0, 2'b00, 1, 0);
    run = 1'b1;
    step();
    run = 1'b0;
    out_ready = 1'b1;
    check("mid_move0", 32'(move_out), 32'(path[0]));
    step();
    check("mid_move1", 32'(move_out), 32'(path[1]));
    step();
    check("mid_move2", 32'(move_out), 32'(path[2]));
    rst = 1'b0; run = 1'b1; start = 1'b1; push = 1'b1;
    step();
    rst = 1'b1; run = 1'b0; start = 1'b0; push = 1'b0; out_ready = 1'b0;
    path.delete();
    recording = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'(0));
    check("mid_rst_count", 32'(count), 32'(0));
    check("mid_rst_pdone", 32'(play_done), 32'(0));
    run = 1'b1;
    step();
    run = 1'b0;
    check("idle_run_valid", 32'(out_valid), 32'(0));
    step();
    check("idle_run_pdone", 32'(play_done), 32'(0));
    check("idle_run_valid2", 32'(out_valid), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_recorder.md
PATH_RECORDER -- requirements
Module: path_recorder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the maximum number of stored moves (one per cell of a 16x16 maze).
REQ-002 Parameter AW, default 8, SHALL set the pointer width; DEPTH = 2**AW.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the synchronous, active-low reset, sampled on rising CLK.
REQ-005 Start  input  1  SHALL be the solve-start pulse (same pulse that starts the rat); it clears and arms recording.
REQ-006 Push  input  1  SHALL be a one-cycle strobe: the rat advanced one cell using Move_in.
REQ-007 Pop  input  1  SHALL be a one-cycle strobe: the rat backtracked one cell.
REQ-008 Move_in  input  2  SHALL be the direction code for Push (00 up, 01 right, 10 left, 11 down).
REQ-009 Done  input  1  SHALL be the rat's solve-success indication.
REQ-010 Fail  input  1  SHALL be the rat's no-path indication.
REQ-011 Run  input  1  SHALL be the replay-request pulse.
REQ-012 Out_ready  input  1  SHALL be the downstream acceptance of Move_out.
REQ-013 Move_out  output  2  SHALL be the replayed direction code.
REQ-014 Out_valid  output  1  SHALL indicate that Move_out holds a valid move.
REQ-015 Play_done  output  1  SHALL indicate that the full path has been replayed.
REQ-016 Count  output  AW+1  SHALL report the number of stored moves (0..DEPTH).
REQ-017 Overflow  output  1  SHALL be a sticky flag: a Push was dropped because the store was full.

Function
REQ-018 The FSM SHALL have states IDLE, RECORD, READY, PLAY, FINISH.
REQ-019 In any state, Start SHALL clear Count, read pointer, Overflow, Out_valid and Play_done, and enter RECORD on the next cycle.
REQ-020 RECORD, Push only: if Count<DEPTH, write Move_in at index Count and increment Count; if Count==DEPTH, drop the push and set Overflow.
REQ-021 RECORD, Pop only: decrement Count if Count>0; Pop at Count==0 SHALL be ignored.
REQ-022 RECORD, Push and Pop in the same cycle: overwrite entry Count-1 with Move_in and leave Count unchanged; at Count==0, treat as Push only.
REQ-023 RECORD, Done: enter READY; a Push/Pop in the same cycle SHALL be applied first.
REQ-024 RECORD, Fail: clear Count and enter IDLE.
REQ-025 Push/Pop outside RECORD SHALL be ignored.
REQ-026 READY or FINISH, Run: clear Play_done, set the read pointer to 0 and enter PLAY; with Count==0, enter FINISH instead and set Play_done the next cycle.
REQ-027 PLAY: Out_valid SHALL rise the cycle after Run was sampled; Move_out SHALL equal stored entry [read pointer].
REQ-028 A transfer SHALL occur on Out_valid && Out_ready; the read pointer then increments and the next entry is presented the following cycle with no bubble.
REQ-029 While Out_valid && !Out_ready, Move_out and Out_valid SHALL stay unchanged.
REQ-030 After the transfer of entry Count-1: Out_valid=0 and Play_done=1 on the next cycle, and the FSM enters FINISH.
REQ-031 Play_done SHALL stay 1 in FINISH until Run or Start; stored moves SHALL survive replay, so Run in FINISH replays the same path.
REQ-032 Run in IDLE, RECORD or PLAY SHALL be ignored.

Reset
REQ-033 With RST==0 at a rising edge: state IDLE, Count=0, read pointer=0, Move_out=00, Out_valid=0, Play_done=0, Overflow=0; the storage array is not cleared.
REQ-034 Reset SHALL override Start, Push, Pop and Run in the same cycle, including in mid-record or mid-replay.

Configuration
REQ-035 Macro PATH_REC_BACKTRACK_EN: if defined, Pop behaves per REQ-021/022; if undefined, Pop SHALL be ignored everywhere (Push+Pop = plain Push) and the design records the raw move trace.

Verification
REQ-036 Start; Push 01,01,11; Done; Run; Out_ready=1 -> Move_out 01,01,11 on three consecutive cycles, then Play_done=1, Count=3.
REQ-037 (BACKTRACK_EN) Push 01, Push 11, Pop, Push 10, Push+Pop with 00, Done, Run -> replay 01,00; Count=2.
REQ-038 257 Pushes at DEPTH=256 -> Count=256, Overflow=1; replay yields exactly 256 moves.
REQ-039 Replay with Out_ready held low for 5 cycles mid-path -> Move_out stable, no move lost or repeated.
REQ-040 RST=0 during PLAY after 2 of 4 transfers -> next cycle Out_valid=0, Count=0, state IDLE; Run then ignored.
REQ-041 Start, Done with no Push, Run -> Out_valid never 1; Play_done=1 two cycles after Run.
